// File: rtl/sub_vram_seq_pkg.sv
// Shared constants, slot phase encoding and address helper for the
// sub-system VRAM slot sequencer.
package sub_vram_seq_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 14'h3FFF;
  localparam int unsigned SLOT_PH = 8;

  typedef enum logic [2:0] {
    PH_RAS     = 3'd0,
    PH_CAS_B   = 3'd1,
    PH_CAS_R   = 3'd2,
    PH_CAS_G   = 3'd3,
    PH_PRE     = 3'd4,
    PH_CPU_RAS = 3'd5,
    PH_CPU_CAS = 3'd6,
    PH_CPU_END = 3'd7
  } phase_t;

  function automatic logic [ADDR_W-1:0] scroll_addr(input logic [ADDR_W-1:0] count,
                                                    input logic [ADDR_W-1:0] ofs);
    return (count + ofs) & ADDR_MASK;
  endfunction

endpackage

// File: rtl/sub_vram_seq_if.sv
// Bundle of the sequencer's timing inputs, CPU handshake and VRAM strobes.
interface sub_vram_seq_if;
  import sub_vram_seq_pkg::*;

  logic              ce;
  logic              sblank_n;
  logic              hde;
  logic              vstart;
  logic [ADDR_W-1:0] scroll_ofs;
  logic              cpu_req;
  logic              cpu_we;
  logic              sras_n;
  logic              sdramv1n;
  logic              sdramv2n;
  logic              sdramv3n;
  logic              scassel;
  logic              srwb;
  logic [ADDR_W-1:0] vaddr;
  logic              shift_ld;
  logic              cpu_ack;

  modport master (
    output ce, sblank_n, hde, vstart, scroll_ofs, cpu_req, cpu_we,
    input  sras_n, sdramv1n, sdramv2n, sdramv3n, scassel, srwb, vaddr, shift_ld, cpu_ack
  );

  modport slave (
    input  ce, sblank_n, hde, vstart, scroll_ofs, cpu_req, cpu_we,
    output sras_n, sdramv1n, sdramv2n, sdramv3n, scassel, srwb, vaddr, shift_ld, cpu_ack
  );

endinterface

// File: rtl/sub_vram_addrgen.sv
// Display fetch address generator: character counter with frame clear,
// scroll offset add and wrap mask.
module sub_vram_addrgen
  import sub_vram_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              vstart,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] scroll_ofs,
  output logic [ADDR_W-1:0] vaddr
);

  logic [ADDR_W-1:0] count;

  // Character counter; frame start wins over the end-of-fetch increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {ADDR_W{1'b0}};
    end else if (vstart) begin
      count <= {ADDR_W{1'b0}};
    end else if (inc) begin
      count <= count + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  // Fetch address is captured on entry to the slot's RAS phase only
  always_ff @(posedge clk) begin
    if (reset) begin
      vaddr <= scroll_addr({ADDR_W{1'b0}}, scroll_ofs);
    end else if (load) begin
      vaddr <= scroll_addr(count, scroll_ofs);
    end else begin
      vaddr <= vaddr;
    end
  end

endmodule

// File: rtl/sub_vram_seq.sv
// Eight-phase character slot sequencer: display fetch in phases 0-3,
// precharge/arbitration in 4, sub-CPU access in 5-7.
module sub_vram_seq
  import sub_vram_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  sub_vram_seq_if.slave bus
);

  phase_t phase;
  phase_t phase_nx;
  logic   fetch;
  logic   fetch_nx;
  logic   pending;
  logic   cpu_active;
  logic   cpu_we_lat;
  logic   req_new;
  logic   cpu_grant;
  logic   ras_d, cas_b_d, cas_r_d, cas_g_d, cpu_cas_d, rw_d;

  assign phase_nx  = phase_t'(phase + 3'd1);
  assign fetch_nx  = (phase == PH_CPU_END) ? (bus.sblank_n & bus.hde) : fetch;
  // A request still visible during service or during the ack cycle is the old one
  assign req_new   = bus.cpu_req & ~cpu_active & ~bus.cpu_ack;
  assign cpu_grant = (phase == PH_CAS_G) & (pending | req_new);

  sub_vram_addrgen u_addrgen (
    .clk        (clk),
    .reset      (reset),
    .vstart     (bus.vstart),
    .inc        (bus.ce & (phase == PH_CAS_G) & fetch),
    .load       (bus.ce & (phase == PH_CPU_END)),
    .scroll_ofs (bus.scroll_ofs),
    .vaddr      (bus.vaddr)
  );

  // Strobe levels for the phase about to be entered
  always_comb begin
    ras_d     = 1'b1;
    cas_b_d   = 1'b1;
    cas_r_d   = 1'b1;
    cas_g_d   = 1'b1;
    cpu_cas_d = 1'b1;
    rw_d      = 1'b1;
    case (phase_nx)
      PH_RAS:   ras_d = ~fetch_nx;
      PH_CAS_B: begin ras_d = ~fetch; cas_b_d = ~fetch; end
      PH_CAS_R: begin ras_d = ~fetch; cas_r_d = ~fetch; end
      PH_CAS_G: begin ras_d = ~fetch; cas_g_d = ~fetch; end
      PH_CPU_RAS, PH_CPU_CAS: begin
        ras_d     = ~cpu_active;
        cpu_cas_d = ~cpu_active;
        rw_d      = cpu_active ? ~cpu_we_lat : 1'b1;
      end
      default:  ras_d = 1'b1;
    endcase
  end

  // Phase counter, slot qualifiers, CPU arbiter and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= PH_RAS;
      fetch        <= 1'b0;
      pending      <= 1'b0;
      cpu_active   <= 1'b0;
      cpu_we_lat   <= 1'b0;
      bus.sras_n   <= 1'b1;
      bus.sdramv1n <= 1'b1;
      bus.sdramv2n <= 1'b1;
      bus.sdramv3n <= 1'b1;
      bus.scassel  <= 1'b1;
      bus.srwb     <= 1'b1;
      bus.shift_ld <= 1'b0;
      bus.cpu_ack  <= 1'b0;
    end else if (bus.ce) begin
      phase        <= phase_nx;
      fetch        <= fetch_nx;
      bus.sras_n   <= ras_d;
      bus.sdramv1n <= cas_b_d;
      bus.sdramv2n <= cas_r_d;
      bus.sdramv3n <= cas_g_d;
      bus.scassel  <= cpu_cas_d;
      bus.srwb     <= rw_d;
      bus.shift_ld <= (phase == PH_CAS_G) & fetch;
      bus.cpu_ack  <= (phase == PH_CPU_CAS) & cpu_active;
      if (cpu_grant) begin
        cpu_active <= 1'b1;
        pending    <= 1'b0;
        cpu_we_lat <= bus.cpu_we;
      end else if (phase == PH_CPU_CAS) begin
        cpu_active <= 1'b0;
        pending    <= pending | req_new;
      end else begin
        pending    <= pending | req_new;
      end
    end else begin
      bus.shift_ld <= 1'b0;
      bus.cpu_ack  <= 1'b0;
    end
  end

endmodule
